sd_adc_decimator: RTL and testbench

Receive side of the first-order sigma-delta link: a first-order sigma-delta ADC loop built from an external comparator and an RC feedback network, plus a decimator. The block samples the comparator bit, drives the feedback pin, and turns the 1-bit density into two's-complement samples. It uses the same midscale convention as the DAC, so its output feeds straight into the codebase's audio and sample paths. Output goes out through a valid/ready handshake.

---
 rtl/sd_adc_decimator.sv | 158 +++++++++++++++
 tb/tb_sd_adc_decimator.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/sd_adc_decimator.sv
// sd_adc_decimator
//   Receive side of a first-order sigma-delta link. Samples an external
//   comparator, drives the RC feedback pin and decimates the 1-bit density
//   into signed two's-complement samples (midscale = 0, density 1 saturates
//   to the most positive code). Samples leave through a valid/ready handshake.
//
//   Build option: define SD_ADC_SINC2_EN to replace the sinc1 ones counter
//   with a second-order CIC (two integrators + two-stage comb). The first
//   sample then appears two edges after the second window end.
//
// Parameters
//   BITS        output sample width (>= DECIM_LOG2, >= 2*DECIM_LOG2 for sinc2)
//   DECIM_LOG2  log2 of decimation ratio R
//   INV         XORed onto fb_out only
//
// Ports
//   clk           single clock
//   reset         synchronous, active-high; clears all state
//   comp_in       asynchronous comparator output
//   fb_out        feedback to the RC network (synchronized bit ^ INV)
//   sample        signed result, stable while sample_valid is high
//   sample_valid  sample holds unconsumed data
//   sample_ready  consumer accepts on an edge where valid & ready
//   overrun       sticky: an unconsumed sample was overwritten
module sd_adc_decimator #(
   parameter int   BITS       = 16,
   parameter int   DECIM_LOG2 = 8,
   parameter logic INV        = 1'b1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            comp_in,
   output logic            fb_out,
   output logic [BITS-1:0] sample,
   output logic            sample_valid,
   input  logic            sample_ready,
   output logic            overrun
);

   logic                  s1;
   logic                  bit_q;
   logic [DECIM_LOG2-1:0] cnt;
   logic                  win_end;

   // ---- stage p0: comparator synchronizer and window counter ----
   always_ff @(posedge clk) begin
      if (reset) begin
         s1    <= 1'b0;
         bit_q <= 1'b0;
         cnt   <= '0;
      end else begin
         s1    <= comp_in;
         bit_q <= s1;
         cnt   <= cnt + 1'b1;
      end
   end

   assign fb_out  = bit_q ^ INV;
   assign win_end = &cnt;

`ifdef SD_ADC_SINC2_EN
   localparam int CW = 2*DECIM_LOG2 + 1;
   localparam int SH = BITS - 2*DECIM_LOG2;

   logic [CW-1:0] integ1, integ2, integ1_nxt, integ2_nxt;
   logic [CW-1:0] z1, z2, d1;
   logic [CW-1:0] c2_p1;
   logic          vld_p1;
   logic          primed;

   // Comb taps the integrator values that already include the current bit,
   // so each window covers exactly R bits, like the sinc1 path.
   assign integ1_nxt = integ1 + CW'(bit_q);
   assign integ2_nxt = integ2 + integ1_nxt;
   assign d1         = integ2_nxt - z1;

   // ---- stage p1: integrators every cycle, comb at window end ----
   always_ff @(posedge clk) begin
      if (reset) begin
         integ1 <= '0;
         integ2 <= '0;
         z1     <= '0;
         z2     <= '0;
         c2_p1  <= '0;
         vld_p1 <= 1'b0;
         primed <= 1'b0;
      end else begin
         integ1 <= integ1_nxt;
         integ2 <= integ2_nxt;
         vld_p1 <= 1'b0;
         if (win_end) begin
            z1     <= integ2_nxt;
            z2     <= d1;
            c2_p1  <= d1 - z2;
            // The first window lacks comb history, so it never emits.
            vld_p1 <= primed;
            primed <= 1'b1;
         end
      end
   end

   logic          load;
   logic [CW-1:0] c_sel;
   assign load  = vld_p1;
   assign c_sel = c2_p1;
`else
   localparam int CW = DECIM_LOG2 + 1;
   localparam int SH = BITS - DECIM_LOG2;

   logic [CW-1:0] ones;
   logic [CW-1:0] c_win;

   // The window-end bit is folded in combinationally so the window counts R bits.
   assign c_win = ones + CW'(bit_q);

   // ---- stage p1: ones counter, reloads at window end ----
   always_ff @(posedge clk) begin
      if (reset)        ones <= '0;
      else if (win_end) ones <= '0;
      else              ones <= c_win;
   end

   logic          load;
   logic [CW-1:0] c_sel;
   assign load  = win_end;
   assign c_sel = c_win;
`endif

   // Maps count c (0..full) onto c*2^SH - 2^(BITS-1); full scale saturates.
   function automatic logic signed [BITS-1:0] scale_sat(input logic [CW-1:0] c);
      logic [BITS-1:0] ext;
      if (c == {1'b1, {(CW-1){1'b0}}})
         return {1'b0, {(BITS-1){1'b1}}};
      ext = BITS'(c) << SH;
      // Subtracting 2^(BITS-1) modulo 2^BITS is an MSB flip.
      return {~ext[BITS-1], ext[BITS-2:0]};
   endfunction

   logic signed [BITS-1:0] result;
   assign result = scale_sat(c_sel);

   // ---- stage p2: output register and handshake ----
   always_ff @(posedge clk) begin
      if (reset) begin
         sample       <= '0;
         sample_valid <= 1'b0;
         overrun      <= 1'b0;
      end else if (load) begin
         sample       <= result;
         sample_valid <= 1'b1;
         if (sample_valid && !sample_ready)
            overrun <= 1'b1;
      end else if (sample_ready) begin
         sample_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sd_adc_decimator.sv
// Directed testbench for sd_adc_decimator at default parameters
// (BITS=16, DECIM_LOG2=8, INV=1). Expected values are hand-computed.
module tb_sd_adc_decimator;

   localparam int R = 256;
`ifdef SD_ADC_SINC2_EN
   localparam int          FIRST_LAT = 2*R + 1;
   localparam logic [15:0] FIRST_VAL = 16'h7FFF;
`else
   // First window loses two bits to the synchronizer fill: 254 ones.
   localparam int          FIRST_LAT = R;
   localparam logic [15:0] FIRST_VAL = 16'h7E00;
`endif

   logic        clk;
   logic        reset;
   logic        comp_in;
   logic        fb_out;
   logic [15:0] sample;
   logic        sample_valid;
   logic        sample_ready;
   logic        overrun;

   int vecs = 0;
   int errs = 0;
   int mode = 0;   // 0 hold comp_in, 1 alternate, 2 one-in-four
   int phase = 0;

   sd_adc_decimator dut (
      .clk          (clk),
      .reset        (reset),
      .comp_in      (comp_in),
      .fb_out       (fb_out),
      .sample       (sample),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .overrun      (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
      phase++;
      case (mode)
         1: comp_in = phase[0];
         2: comp_in = (phase % 4 == 0);
         default: ;
      endcase
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      sample_ready = 1'b1;
      mode = 1;
      repeat (10) tick();
      vecs++; if (sample !== 16'h0000) begin errs++; $display("FAIL reset_sample got %h want 0000", sample); end
      vecs++; if (sample_valid !== 1'b0) begin errs++; $display("FAIL reset_valid got %b want 0", sample_valid); end
      vecs++; if (overrun !== 1'b0) begin errs++; $display("FAIL reset_overrun got %b want 0", overrun); end
      vecs++; if (fb_out !== 1'b1) begin errs++; $display("FAIL reset_fb got %b want 1", fb_out); end
      reset = 1'b0;
      mode = 0;
   endtask

   task automatic test_fb();
      comp_in = 1'b0;
      repeat (3) tick();
      vecs++; if (fb_out !== 1'b1) begin errs++; $display("FAIL fb_zero got %b want 1", fb_out); end
      comp_in = 1'b1;
      tick();
      vecs++; if (fb_out !== 1'b1) begin errs++; $display("FAIL fb_rise_d1 got %b want 1", fb_out); end
      tick();
      vecs++; if (fb_out !== 1'b0) begin errs++; $display("FAIL fb_rise_d2 got %b want 0", fb_out); end
      comp_in = 1'b0;
      tick();
      vecs++; if (fb_out !== 1'b0) begin errs++; $display("FAIL fb_fall_d1 got %b want 0", fb_out); end
      tick();
      vecs++; if (fb_out !== 1'b1) begin errs++; $display("FAIL fb_fall_d2 got %b want 1", fb_out); end
   endtask

   task automatic test_const_one();
      mode = 0;
      comp_in = 1'b1;
      sample_ready = 1'b1;
      do_reset();
      repeat (FIRST_LAT-1) tick();
      vecs++; if (sample_valid !== 1'b0) begin errs++; $display("FAIL first_early got %b want 0", sample_valid); end
      tick();
      vecs++; if (sample_valid !== 1'b1) begin errs++; $display("FAIL first_valid got %b want 1", sample_valid); end
      vecs++; if (sample !== FIRST_VAL) begin errs++; $display("FAIL first_value got %h want %h", sample, FIRST_VAL); end
      tick();
      vecs++; if (sample_valid !== 1'b0) begin errs++; $display("FAIL accept_clear got %b want 0", sample_valid); end
      repeat (R-1) tick();
      vecs++; if (sample_valid !== 1'b1) begin errs++; $display("FAIL ones_valid got %b want 1", sample_valid); end
      vecs++; if (sample !== 16'h7FFF) begin errs++; $display("FAIL ones_value got %h want 7fff", sample); end
      vecs++; if (fb_out !== 1'b0) begin errs++; $display("FAIL ones_fb got %b want 0", fb_out); end
      tick();
      repeat (R-1) tick();
      vecs++; if (sample !== 16'h7FFF || sample_valid !== 1'b1) begin errs++; $display("FAIL ones_again got %h/%b want 7fff/1", sample, sample_valid); end
   endtask

   task automatic test_patterns();
      logic [15:0] want [3];
      int          pm   [3];
      want[0] = 16'h8000; pm[0] = 0;
      want[1] = 16'h0000; pm[1] = 1;
      want[2] = 16'hC000; pm[2] = 2;
      sample_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         comp_in = 1'b0;
         mode = pm[k];
         do_reset();
         repeat (FIRST_LAT + R) tick();
         vecs++;
         if (sample_valid !== 1'b1 || sample !== want[k]) begin
            errs++;
            $display("FAIL pattern%0d got %h/%b want %h/1", k, sample, sample_valid, want[k]);
         end
      end
      mode = 0;
   endtask

   task automatic test_overrun();
      comp_in = 1'b1;
      sample_ready = 1'b0;
      do_reset();
      repeat (FIRST_LAT) tick();
      vecs++; if (sample_valid !== 1'b1 || sample !== FIRST_VAL) begin errs++; $display("FAIL ovr_first got %h/%b want %h/1", sample, sample_valid, FIRST_VAL); end
      repeat (R-1) tick();
      vecs++; if (sample_valid !== 1'b1 || sample !== FIRST_VAL) begin errs++; $display("FAIL ovr_hold got %h/%b want %h/1", sample, sample_valid, FIRST_VAL); end
      vecs++; if (overrun !== 1'b0) begin errs++; $display("FAIL ovr_early got %b want 0", overrun); end
      tick();
      vecs++; if (overrun !== 1'b1) begin errs++; $display("FAIL ovr_set got %b want 1", overrun); end
      vecs++; if (sample !== 16'h7FFF || sample_valid !== 1'b1) begin errs++; $display("FAIL ovr_new got %h/%b want 7fff/1", sample, sample_valid); end
      repeat (40) tick();
      sample_ready = 1'b1;
      tick();
      vecs++; if (sample_valid !== 1'b0) begin errs++; $display("FAIL ovr_accept got %b want 0", sample_valid); end
      repeat (5) tick();
      vecs++; if (overrun !== 1'b1) begin errs++; $display("FAIL ovr_sticky got %b want 1", overrun); end
   endtask

   task automatic test_ready_coincident();
      comp_in = 1'b1;
      sample_ready = 1'b0;
      do_reset();
      repeat (FIRST_LAT) tick();
      vecs++; if (sample_valid !== 1'b1) begin errs++; $display("FAIL coin_first got %b want 1", sample_valid); end
      repeat (R-1) tick();
      sample_ready = 1'b1;
      tick();
      vecs++; if (sample_valid !== 1'b1 || sample !== 16'h7FFF) begin errs++; $display("FAIL coin_new got %h/%b want 7fff/1", sample, sample_valid); end
      vecs++; if (overrun !== 1'b0) begin errs++; $display("FAIL coin_overrun got %b want 0", overrun); end
      tick();
      vecs++; if (sample_valid !== 1'b0) begin errs++; $display("FAIL coin_accept got %b want 0", sample_valid); end
   endtask

   task automatic test_reset_mid();
      comp_in = 1'b1;
      sample_ready = 1'b0;
      do_reset();
      repeat (FIRST_LAT + 100) tick();
      reset = 1'b1;
      repeat (3) tick();
      vecs++; if (sample_valid !== 1'b0 || sample !== 16'h0000 || overrun !== 1'b0) begin errs++; $display("FAIL mid_clear got %h/%b/%b want 0000/0/0", sample, sample_valid, overrun); end
      reset = 1'b0;
      repeat (FIRST_LAT-1) tick();
      vecs++; if (sample_valid !== 1'b0) begin errs++; $display("FAIL mid_early got %b want 0", sample_valid); end
      tick();
      vecs++; if (sample_valid !== 1'b1 || sample !== FIRST_VAL) begin errs++; $display("FAIL mid_first got %h/%b want %h/1", sample, sample_valid, FIRST_VAL); end
      // Reset asserted on the load edge must win.
      do_reset();
      repeat (FIRST_LAT-1) tick();
      reset = 1'b1;
      tick();
      vecs++; if (sample_valid !== 1'b0) begin errs++; $display("FAIL reset_wins got %b want 0", sample_valid); end
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      comp_in = 1'b0;
      sample_ready = 1'b0;
      test_reset();
      test_fb();
      test_const_one();
      test_patterns();
      test_overrun();
      test_ready_coincident();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
